// File: rtl/pc_fetch_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, applies decode redirects (1-cycle redirect-to-fetch), traps misaligned targets.
// A stall holds the PC and buffers the newest aligned redirect until the stall drops.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStall,
    input  logic        iRedirectValid,
    input  logic [31:0] iRedirectTarget,
    input  logic        iTrapAck,
    output logic [31:0] oPCF,
    output logic [31:0] oPCPlus4F,
    output logic        oFetchValid,
    output logic        oFlushD,
    output logic        oMisalignedTrap,
    output logic [31:0] oTrapPC
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        flush_q, flush_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        redirect_misaligned;

    assign redirect_misaligned = iRedirectValid && (iRedirectTarget[1:0] != 2'b00);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
            flush_q    <= 1'b0;
            trap_pc_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= flush_d;
            trap_pc_q  <= trap_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        trap_pc_d  = trap_pc_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                // A misaligned target traps even while stalled; the PC holds on the faulting path.
                if (redirect_misaligned) begin
                    state_d   = S_TRAP;
                    trap_pc_d = iRedirectTarget;
                    flush_d   = 1'b1;
                end else if (iStall) begin
                    if (iRedirectValid) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = iRedirectTarget;
                    end
                end else if (iRedirectValid) begin
                    pc_d       = iRedirectTarget;
                    pend_vld_d = 1'b0;
                    flush_d    = 1'b1;
                end else if (pend_vld_q) begin
                    pc_d       = pend_tgt_q;
                    pend_vld_d = 1'b0;
                    flush_d    = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_TRAP: begin
                if (iTrapAck) begin
                    state_d    = S_RUN;
                    pc_d       = TRAP_VECTOR;
                    pend_vld_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        oFetchValid     = (state_q == S_RUN);
        oMisalignedTrap = (state_q == S_TRAP);
        oPCF            = pc_q;
        oPCPlus4F       = pc_q + 32'd4;
        oFlushD         = flush_q;
        oTrapPC         = trap_pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: each task drives a scenario and checks hand-computed values.
module tb_pc_fetch_sequencer;

    logic        iClk;
    logic        iRst;
    logic        iStall;
    logic        iRedirectValid;
    logic [31:0] iRedirectTarget;
    logic        iTrapAck;
    logic [31:0] oPCF;
    logic [31:0] oPCPlus4F;
    logic        oFetchValid;
    logic        oFlushD;
    logic        oMisalignedTrap;
    logic [31:0] oTrapPC;

    int tests_run;
    int tests_failed;

    pc_fetch_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iStall         (iStall),
        .iRedirectValid (iRedirectValid),
        .iRedirectTarget(iRedirectTarget),
        .iTrapAck       (iTrapAck),
        .oPCF           (oPCF),
        .oPCPlus4F      (oPCPlus4F),
        .oFetchValid    (oFetchValid),
        .oFlushD        (oFlushD),
        .oMisalignedTrap(oMisalignedTrap),
        .oTrapPC        (oTrapPC)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        iRst = 1'b1;
        tick();
        tests_run++;
        if (oPCF !== 32'h0 || oFetchValid !== 1'b0 || oFlushD !== 1'b0 ||
            oMisalignedTrap !== 1'b0 || oTrapPC !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h fv=%b flush=%b trap=%b trappc=%h, required pc=0 fv=0 flush=0 trap=0 trappc=0",
                     oPCF, oFetchValid, oFlushD, oMisalignedTrap, oTrapPC);
        end
        iRst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (oPCF !== exp_pc[i] || oFetchValid !== 1'b1 || oFlushD !== 1'b0) begin
                tests_failed++;
                $display("FAIL run_seq[%0d]: pc=%h fv=%b flush=%b, required pc=%h fv=1 flush=0",
                         i, oPCF, oFetchValid, oFlushD, exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect();
        tick();
        tests_run++;
        if (oPCF !== 32'h10) begin
            tests_failed++;
            $display("FAIL redir_pre: pc=%h, required 00000010", oPCF);
        end
        iRedirectValid = 1'b1; iRedirectTarget = 32'h200;
        tick();
        iRedirectValid = 1'b0;
        tests_run++;
        if (oPCF !== 32'h200 || oFlushD !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_apply: pc=%h flush=%b, required pc=00000200 flush=1", oPCF, oFlushD);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h204 || oFlushD !== 1'b0 || oPCPlus4F !== 32'h208) begin
            tests_failed++;
            $display("FAIL redir_after: pc=%h flush=%b plus4=%h, required pc=00000204 flush=0 plus4=00000208",
                     oPCF, oFlushD, oPCPlus4F);
        end
    endtask

    task automatic test_stall();
        logic [31:0] tgt [3];
        logic        vld [3];
        tgt[0] = 32'h80; tgt[1] = 32'h90; tgt[2] = 32'h0;
        vld[0] = 1'b1;   vld[1] = 1'b1;   vld[2] = 1'b0;
        iRedirectValid = 1'b1; iRedirectTarget = 32'h40;
        tick();
        tests_run++;
        if (oPCF !== 32'h40 || oFlushD !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_setup: pc=%h flush=%b, required pc=00000040 flush=1", oPCF, oFlushD);
        end
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iRedirectValid = vld[i]; iRedirectTarget = tgt[i];
            tick();
            tests_run++;
            if (oPCF !== 32'h40 || oFlushD !== 1'b0 || oFetchValid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h flush=%b fv=%b, required pc=00000040 flush=0 fv=1",
                         i, oPCF, oFlushD, oFetchValid);
            end
        end
        iStall = 1'b0; iRedirectValid = 1'b0;
        tick();
        tests_run++;
        if (oPCF !== 32'h90 || oFlushD !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h flush=%b, required pc=00000090 flush=1", oPCF, oFlushD);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h94 || oFlushD !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_after: pc=%h flush=%b, required pc=00000094 flush=0", oPCF, oFlushD);
        end
        // pending entry overridden by a redirect arriving as the stall drops
        iStall = 1'b1; iRedirectValid = 1'b1; iRedirectTarget = 32'h300;
        tick();
        iStall = 1'b0; iRedirectTarget = 32'h400;
        tick();
        iRedirectValid = 1'b0;
        tests_run++;
        if (oPCF !== 32'h400 || oFlushD !== 1'b1) begin
            tests_failed++;
            $display("FAIL pend_override: pc=%h flush=%b, required pc=00000400 flush=1", oPCF, oFlushD);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h404 || oFlushD !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_cleared: pc=%h flush=%b, required pc=00000404 flush=0", oPCF, oFlushD);
        end
    endtask

    task automatic test_trap();
        // PC is 0x404 entering this task
        iRedirectValid = 1'b1; iRedirectTarget = 32'h102;
        tick();
        tests_run++;
        if (oMisalignedTrap !== 1'b1 || oTrapPC !== 32'h102 || oFetchValid !== 1'b0 ||
            oFlushD !== 1'b1 || oPCF !== 32'h404) begin
            tests_failed++;
            $display("FAIL trap_enter: trap=%b trappc=%h fv=%b flush=%b pc=%h, required trap=1 trappc=00000102 fv=0 flush=1 pc=00000404",
                     oMisalignedTrap, oTrapPC, oFetchValid, oFlushD, oPCF);
        end
        iRedirectTarget = 32'h500; iStall = 1'b1;
        tick();
        iStall = 1'b0;
        tick();
        iRedirectValid = 1'b0;
        tests_run++;
        if (oMisalignedTrap !== 1'b1 || oPCF !== 32'h404 || oFlushD !== 1'b0 || oFetchValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_ignore: trap=%b pc=%h flush=%b fv=%b, required trap=1 pc=00000404 flush=0 fv=0",
                     oMisalignedTrap, oPCF, oFlushD, oFetchValid);
        end
        iTrapAck = 1'b1;
        tick();
        iTrapAck = 1'b0;
        tests_run++;
        if (oPCF !== 32'h100 || oFetchValid !== 1'b1 || oMisalignedTrap !== 1'b0 || oTrapPC !== 32'h102) begin
            tests_failed++;
            $display("FAIL trap_ack: pc=%h fv=%b trap=%b trappc=%h, required pc=00000100 fv=1 trap=0 trappc=00000102",
                     oPCF, oFetchValid, oMisalignedTrap, oTrapPC);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h104 || oFlushD !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_resume: pc=%h flush=%b, required pc=00000104 flush=0", oPCF, oFlushD);
        end
    endtask

    task automatic test_wrap();
        iRedirectValid = 1'b1; iRedirectTarget = 32'hFFFF_FFF8;
        tick();
        iRedirectValid = 1'b0;
        tests_run++;
        if (oPCF !== 32'hFFFF_FFF8 || oFlushD !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_0: pc=%h flush=%b, required pc=fffffff8 flush=1", oPCF, oFlushD);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'hFFFF_FFFC || oPCPlus4F !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_1: pc=%h plus4=%h, required pc=fffffffc plus4=00000000", oPCF, oPCPlus4F);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h0 || oFetchValid !== 1'b1 || oMisalignedTrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_2: pc=%h fv=%b trap=%b, required pc=00000000 fv=1 trap=0",
                     oPCF, oFetchValid, oMisalignedTrap);
        end
    endtask

    task automatic test_reset_mid_trap();
        iStall = 1'b1; iRedirectValid = 1'b1; iRedirectTarget = 32'h600;
        tick();
        iRedirectTarget = 32'h7;
        tick();
        iRedirectValid = 1'b0; iStall = 1'b0;
        tests_run++;
        if (oMisalignedTrap !== 1'b1 || oTrapPC !== 32'h7) begin
            tests_failed++;
            $display("FAIL mid_trap_enter: trap=%b trappc=%h, required trap=1 trappc=00000007",
                     oMisalignedTrap, oTrapPC);
        end
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        tests_run++;
        if (oMisalignedTrap !== 1'b0 || oPCF !== 32'h0 || oFetchValid !== 1'b0 || oTrapPC !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_trap_reset: trap=%b pc=%h fv=%b trappc=%h, required trap=0 pc=0 fv=0 trappc=0",
                     oMisalignedTrap, oPCF, oFetchValid, oTrapPC);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h0 || oFetchValid !== 1'b1 || oFlushD !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_trap_boot: pc=%h fv=%b flush=%b, required pc=0 fv=1 flush=0",
                     oPCF, oFetchValid, oFlushD);
        end
        tick();
        tests_run++;
        if (oPCF !== 32'h4 || oFlushD !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_trap_nopend: pc=%h flush=%b, required pc=00000004 flush=0", oPCF, oFlushD);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        iRst            = 1'b1;
        iStall          = 1'b0;
        iRedirectValid  = 1'b0;
        iRedirectTarget = 32'h0;
        iTrapAck        = 1'b0;
        #2;
        test_reset();
        test_redirect();
        test_stall();
        test_trap();
        test_wrap();
        test_reset_mid_trap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
